// File: rtl/btn_evt_pkg.sv
// Shared event-type codes, repeat-FSM state encoding and a width helper for the
// button event scheduler.
package btn_evt_pkg;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'b00,
        RPT_DELAY  = 2'b01,
        RPT_REPEAT = 2'b10
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO whose head entry, valid flag and occupancy are all
// registered, so the consumer sees stable outputs straight from flops.
module btn_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          head_valid_r;
    logic [W-1:0]  head_data_r;
    logic [W-1:0]  head_nxt_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Next pointers/occupancy and the entry that will sit at the head next cycle
    always_comb begin
        do_push_s    = push && (count_r != (AW+1)'(DEPTH));
        do_pop_s     = pop && head_valid_r;
        rd_ptr_nxt_s = do_pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + (AW+1)'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_nxt_s = count_r - (AW+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
        // A push landing on the next head slot can only happen when nothing older remains
        if (do_push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            head_valid_r <= 1'b0;
            head_data_r  <= '0;
        end else begin
            wr_ptr_r     <= do_push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != '0);
            head_data_r  <= (count_nxt_s != '0) ? head_nxt_s : '0;
        end
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;
    assign count      = count_r;

endmodule

// File: rtl/button_event_scheduler.sv
// Round-robin arbiter turning debounced button pulses into a FIFO'd event stream.
// Optional auto-repeat generator enabled by defining BTN_AUTOREPEAT_EN.
module button_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter int NB            = 4,
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NB-1:0]           pb_pressed_pulse,
    input  logic [NB-1:0]           pb_released_pulse,
    input  logic [NB-1:0]           pb_pressed_state,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [1:0]              evt_type,
    output logic [$clog2(NB)-1:0]   evt_id,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    input  logic                    ovf_clear
);
    localparam int IDW = $clog2(NB);
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [NB-1:0]  p_r, r_r, l_r;
    logic [NB-1:0]  gnt_p_s, gnt_r_s, gnt_l_s;
    logic [NB-1:0]  rpt_set_s;
    logic [IDW-1:0] rr_r;
    logic [IDW-1:0] scan_id_s;
    logic [IDW-1:0] gnt_id_s;
    logic           gnt_valid_s;
    logic [1:0]     gnt_type_s;
    logic           lost_s;
    logic           overflow_r;
    logic [CW-1:0]  count_s;
    logic [IDW+1:0] head_data_s;

    // Round-robin scan: offsets are visited high to low so the nearest one to rr wins
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = '0;
        gnt_type_s  = EVT_NONE;
        gnt_p_s     = '0;
        gnt_r_s     = '0;
        gnt_l_s     = '0;
        scan_id_s   = '0;
        if (count_s < CW'(DEPTH)) begin
            for (int i = NB - 1; i >= 0; i--) begin
                scan_id_s = IDW'((int'(rr_r) + i) % NB);
                if (p_r[scan_id_s] || r_r[scan_id_s] || l_r[scan_id_s]) begin
                    gnt_valid_s = 1'b1;
                    gnt_id_s    = scan_id_s;
                end else begin
                    gnt_valid_s = gnt_valid_s;
                end
            end
        end else begin
            gnt_valid_s = 1'b0;
        end
        // Press before repeat before release keeps press-before-release ordering
        if (gnt_valid_s) begin
            if (p_r[gnt_id_s]) begin
                gnt_type_s          = EVT_PRESS;
                gnt_p_s[gnt_id_s]   = 1'b1;
            end else if (r_r[gnt_id_s]) begin
                gnt_type_s          = EVT_REPEAT;
                gnt_r_s[gnt_id_s]   = 1'b1;
            end else begin
                gnt_type_s          = EVT_RELEASE;
                gnt_l_s[gnt_id_s]   = 1'b1;
            end
        end else begin
            gnt_type_s = EVT_NONE;
        end
        lost_s = |((pb_pressed_pulse  & p_r & ~gnt_p_s) |
                   (rpt_set_s         & r_r & ~gnt_r_s) |
                   (pb_released_pulse & l_r & ~gnt_l_s));
    end

    // Pending bits, round-robin pointer and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            p_r        <= '0;
            r_r        <= '0;
            l_r        <= '0;
            rr_r       <= '0;
            overflow_r <= 1'b0;
        end else begin
            p_r <= (p_r & ~gnt_p_s) | pb_pressed_pulse;
            r_r <= (r_r & ~gnt_r_s) | rpt_set_s;
            l_r <= (l_r & ~gnt_l_s) | pb_released_pulse;
            if (gnt_valid_s) begin
                rr_r <= (gnt_id_s == IDW'(NB - 1)) ? '0 : (gnt_id_s + IDW'(1));
            end
            if (lost_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clear) begin
                overflow_r <= 1'b0;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNTW = (RMAX > 1) ? $clog2(RMAX) : 1;

    for (genvar b = 0; b < NB; b++) begin : g_rpt
        rpt_state_e     state_r, state_nxt_s;
        logic [CNTW-1:0] cnt_r, cnt_nxt_s;
        logic           set_s;

        // Hold-time counter: first repeat after the delay, then every period
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            set_s       = 1'b0;
            case (state_r)
                RPT_IDLE: begin
                    if (pb_pressed_pulse[b]) begin
                        state_nxt_s = RPT_DELAY;
                        cnt_nxt_s   = '0;
                    end else begin
                        state_nxt_s = RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (!pb_pressed_state[b]) begin
                        state_nxt_s = RPT_IDLE;
                    end else if (cnt_r == CNTW'(REPEAT_DELAY - 1)) begin
                        set_s       = 1'b1;
                        state_nxt_s = RPT_REPEAT;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNTW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!pb_pressed_state[b]) begin
                        state_nxt_s = RPT_IDLE;
                    end else if (cnt_r == CNTW'(REPEAT_PERIOD - 1)) begin
                        set_s       = 1'b1;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNTW'(1);
                    end
                end
                default: begin
                    state_nxt_s = RPT_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end

        // Repeat FSM state register
        always_ff @(posedge clock) begin
            if (reset) begin
                state_r <= RPT_IDLE;
                cnt_r   <= '0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
            end
        end

        assign rpt_set_s[b] = set_s;
    end
`else
    logic unused_rpt_s;
    assign rpt_set_s    = '0;
    assign unused_rpt_s = ^{pb_pressed_state, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    btn_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (IDW + 2)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (gnt_valid_s),
        .push_data  ({gnt_type_s, gnt_id_s}),
        .pop        (evt_ready),
        .head_valid (evt_valid),
        .head_data  (head_data_s),
        .count      (count_s)
    );

    assign evt_type   = head_data_s[IDW+1:IDW];
    assign evt_id     = head_data_s[IDW-1:0];
    assign fifo_count = count_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed self-checking bench for button_event_scheduler (NB=4, DEPTH=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=5); expectations follow BTN_AUTOREPEAT_EN.
module tb_button_event_scheduler;
    localparam int NB    = 4;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] pb_pressed_pulse  = '0;
    logic [NB-1:0] pb_released_pulse = '0;
    logic [NB-1:0] pb_pressed_state  = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clear = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_type;
    logic [1:0]    evt_id;
    logic [2:0]    fifo_count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0] t;
        logic [1:0] id;
        int         c;
    } ev_t;
    ev_t evq[$];

    button_event_scheduler #(
        .NB(NB), .DEPTH(DEPTH), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clock(clock), .reset(reset),
        .pb_pressed_pulse(pb_pressed_pulse), .pb_released_pulse(pb_released_pulse),
        .pb_pressed_state(pb_pressed_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type), .evt_id(evt_id),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record every accepted event with the cycle it was presented in
    always @(negedge clock) begin
        if (evt_valid === 1'b1 && evt_ready === 1'b1)
            evq.push_back('{t: evt_type, id: evt_id, c: cyc});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
        n_tests++; if (evt_type !== 2'b00) begin n_fail++; $display("FAIL reset_type got %b want 00", evt_type); end
        n_tests++; if (evt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", evt_id); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_single_press();
        int t0;
        evt_ready = 1'b1;
        evq.delete();
        pb_pressed_pulse = 4'b0100;
        t0 = cyc;
        step(1);
        pb_pressed_pulse = '0;
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %0b want 0", evt_valid); end
        step(1);
        n_tests++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", evt_valid); end
        n_tests++; if (evt_type !== 2'b01) begin n_fail++; $display("FAIL single_type got %b want 01", evt_type); end
        n_tests++; if (evt_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", evt_id); end
        step(48);
        pb_released_pulse = 4'b0100;
        step(1);
        pb_released_pulse = '0;
        step(3);
        n_tests++; if (evq.size() !== 2) begin n_fail++; $display("FAIL single_count got %0d want 2", evq.size()); end
        if (evq.size() >= 2) begin
            n_tests++;
            if (evq[0].t !== 2'b01 || evq[0].id !== 2'd2 || evq[0].c !== t0 + 2) begin
                n_fail++; $display("FAIL single_press_evt got t=%b id=%0d c=%0d want t=01 id=2 c=%0d", evq[0].t, evq[0].id, evq[0].c, t0 + 2);
            end
            n_tests++;
            if (evq[1].t !== 2'b10 || evq[1].id !== 2'd2 || evq[1].c !== t0 + 52) begin
                n_fail++; $display("FAIL single_release_evt got t=%b id=%0d c=%0d want t=10 id=2 c=%0d", evq[1].t, evq[1].id, evq[1].c, t0 + 52);
            end
        end
    endtask

    task automatic test_simultaneous();
        int t0, t1;
        logic [1:0] exp_id [7];
        int         exp_c  [7];
        reset = 1'b1; step(1); reset = 1'b0;
        evt_ready = 1'b1;
        evq.delete();
        pb_pressed_pulse = 4'b1011; t0 = cyc; step(1); pb_pressed_pulse = '0;
        step(6);
        pb_pressed_pulse = 4'b1111; t1 = cyc; step(1); pb_pressed_pulse = '0;
        step(7);
        exp_id = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        exp_c  = '{t0 + 2, t0 + 3, t0 + 4, t1 + 2, t1 + 3, t1 + 4, t1 + 5};
        n_tests++; if (evq.size() !== 7) begin n_fail++; $display("FAIL simul_count got %0d want 7", evq.size()); end
        for (int i = 0; i < 7 && i < evq.size(); i++) begin
            n_tests++;
            if (evq[i].t !== 2'b01 || evq[i].id !== exp_id[i] || evq[i].c !== exp_c[i]) begin
                n_fail++; $display("FAIL simul_evt%0d got t=%b id=%0d c=%0d want t=01 id=%0d c=%0d", i, evq[i].t, evq[i].id, evq[i].c, exp_id[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_t  [6];
        logic [1:0] exp_id [6];
        reset = 1'b1; step(1); reset = 1'b0;
        evt_ready = 1'b0;
        evq.delete();
        pb_pressed_pulse = 4'b1111; step(1); pb_pressed_pulse = '0;
        pb_released_pulse = 4'b0011; step(1); pb_released_pulse = '0;
        step(6);
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_full got %0d want 4", fifo_count); end
        step(1);
        n_tests++; if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_id !== 2'd0) begin
            n_fail++; $display("FAIL bp_head got v=%0b t=%b id=%0d want v=1 t=01 id=0", evt_valid, evt_type, evt_id);
        end
        evt_ready = 1'b1;
        step(10);
        exp_t  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n_tests++; if (evq.size() !== 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", evq.size()); end
        for (int i = 0; i < 6 && i < evq.size(); i++) begin
            n_tests++;
            if (evq[i].t !== exp_t[i] || evq[i].id !== exp_id[i]) begin
                n_fail++; $display("FAIL bp_evt%0d got t=%b id=%0d want t=%b id=%0d", i, evq[i].t, evq[i].id, exp_t[i], exp_id[i]);
            end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        reset = 1'b1; step(1); reset = 1'b0;
        evt_ready = 1'b0;
        evq.delete();
        pb_pressed_pulse = 4'b1111; step(1); pb_pressed_pulse = '0;
        step(6);
        pb_pressed_pulse = 4'b0010; step(1); pb_pressed_pulse = '0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_first got %0b want 0", overflow); end
        pb_pressed_pulse = 4'b0010; step(1); pb_pressed_pulse = '0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b want 1", overflow); end
        pb_pressed_pulse = 4'b0010; ovf_clear = 1'b1; step(1); pb_pressed_pulse = '0; ovf_clear = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_prio got %0b want 1", overflow); end
        ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b want 0", overflow); end
        evt_ready = 1'b1;
        step(10);
        n_tests++; if (evq.size() !== 5) begin n_fail++; $display("FAIL ovf_drain got %0d want 5", evq.size()); end
        if (evq.size() >= 5) begin
            n_tests++; if (evq[4].t !== 2'b01 || evq[4].id !== 2'd1) begin
                n_fail++; $display("FAIL ovf_last got t=%b id=%0d want t=01 id=1", evq[4].t, evq[4].id);
            end
        end
    endtask

    task automatic test_autorepeat();
        int t0;
`ifdef BTN_AUTOREPEAT_EN
        localparam int NE = 6;
        logic [1:0] exp_t [NE] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
        int         exp_o [NE] = '{2, 22, 27, 32, 37, 42};
`else
        localparam int NE = 2;
        logic [1:0] exp_t [NE] = '{2'b01, 2'b10};
        int         exp_o [NE] = '{2, 42};
`endif
        reset = 1'b1; step(1); reset = 1'b0;
        evt_ready = 1'b1;
        evq.delete();
        pb_pressed_pulse = 4'b0001; pb_pressed_state = 4'b0001; t0 = cyc;
        step(1);
        pb_pressed_pulse = '0;
        step(39);
        pb_pressed_state = '0; pb_released_pulse = 4'b0001;
        step(1);
        pb_released_pulse = '0;
        step(5);
        n_tests++; if (evq.size() !== NE) begin n_fail++; $display("FAIL rpt_count got %0d want %0d", evq.size(), NE); end
        for (int i = 0; i < NE && i < evq.size(); i++) begin
            n_tests++;
            if (evq[i].t !== exp_t[i] || evq[i].id !== 2'd0 || evq[i].c !== t0 + exp_o[i]) begin
                n_fail++; $display("FAIL rpt_evt%0d got t=%b id=%0d c=%0d want t=%b id=0 c=%0d", i, evq[i].t, evq[i].id, evq[i].c, exp_t[i], t0 + exp_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; step(1); reset = 1'b0;
        evt_ready = 1'b0;
        evq.delete();
        pb_pressed_pulse = 4'b0111; step(1); pb_pressed_pulse = '0;
        step(4);
        n_tests++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_fill got %0d want 3", fifo_count); end
        pb_pressed_pulse = 4'b1000; step(1); pb_pressed_pulse = '0;
        reset = 1'b1; step(1); reset = 1'b0;
        n_tests++; if (evt_valid !== 1'b0 || fifo_count !== 3'd0 || evt_type !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset got v=%0b cnt=%0d t=%b want v=0 cnt=0 t=00", evt_valid, fifo_count, evt_type);
        end
        evt_ready = 1'b1;
        step(10);
        n_tests++; if (evq.size() !== 0) begin n_fail++; $display("FAIL mid_stale got %0d events want 0", evq.size()); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_backpressure();
        test_overflow();
        test_autorepeat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Collects the debounced press/release pulses and pressed-state levels of NB push-button debouncers and turns them into an ordered stream of button events. Simultaneous events are arbitrated round-robin, buffered in a small FIFO and handed to the consumer (menu/FSM logic) over a valid/ready handshake. An optional per-button auto-repeat generator emits repeat events while a button is held.

## Interface
- NB, 4: number of buttons (2..8)
- DEPTH, 4: event FIFO depth (power of two, ≥2)
- REPEAT_DELAY, 1000: held cycles after press before the first repeat event
- REPEAT_PERIOD, 250: cycles between subsequent repeat events
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- pb_pressed_pulse  in  NB  one-cycle press pulse per button, from debouncers
- pb_released_pulse  in  NB  one-cycle release pulse per button
- pb_pressed_state  in  NB  debounced held level per button
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_type  out  2  01 press, 10 release, 11 repeat; 00 when FIFO empty
- evt_id  out  $clog2(NB)  button index of head event; 0 when empty
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: an event was lost
- ovf_clear  in  1  clears overflow (set has priority if same cycle)

## Operation
- Per button, three pending bits P (press), R (repeat), L (release). A pulse sets its bit at the next edge.
- Lost event: pulse arrives while its bit is already set and not granted this cycle → bit stays set, overflow ← 1. Pulse on a bit granted this cycle → bit remains set (new event), no overflow.
- Arbiter (combinational): if fifo_count < DEPTH, grant the first button with any pending bit, scanning from pointer rr upward modulo NB. Within a button, priority P > R > L (preserves press-before-release order). Granted bit clears; event {type,id} is pushed; rr ← granted id + 1 mod NB. No grant → rr unchanged.
- Full FIFO: no grant; pending bits hold. Push is gated on registered count only: full plus a simultaneous pop still does not push that cycle.
- FIFO: pop when evt_valid & evt_ready; simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Reset: all pending bits 0, rr = 0, FIFO empty, evt_valid 0, evt_type 00, evt_id 0, fifo_count 0, overflow 0, repeat FSMs IDLE. Reset mid-operation discards all pending and buffered events.

## Timing
- Pulse in cycle t → pending set at edge end of t → granted and pushed in t+1 → evt_valid in t+2 if FIFO was empty and no competing button (latency 2).
- NB simultaneous presses on an empty FIFO emit one event per cycle, in order rr, rr+1, …
- evt_type/evt_id are registered FIFO-head outputs, stable while evt_valid & !evt_ready.

## Configuration
- BTN_AUTOREPEAT_EN defined: per-button FSM IDLE → DELAY on press pulse (counter 0). DELAY: counts while pb_pressed_state=1; at count REPEAT_DELAY-1 sets R and goes to REPEAT with counter 0. REPEAT: at count REPEAT_PERIOD-1 sets R, counter 0. In DELAY or REPEAT, pb_pressed_state=0 → IDLE (a pending R is still emitted). Counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
- Undefined: no repeat FSMs or counters; R bits are tied to 0; type 11 is never emitted.

## Structure
- Package btn_evt_pkg: event type constants EVT_NONE=2'b00, EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_REPEAT=2'b11; repeat FSM state encodings.
- Sub-module btn_evt_fifo (synchronous FIFO, DEPTH × (2+$clog2(NB)) bits, count output). Arbiter and repeat FSMs stay in the top.

## Test plan
- Single press on button 2 at cycle 10, evt_ready=1 → evt_valid in cycle 12 with type 01, id 2; release 50 cycles later → type 10, id 2.
- Presses on buttons 0,1,3 in the same cycle, rr=0 → events ids 0,1,3 on three consecutive cycles; then press all four → ids 0,1,2,3 (rr=0 after id 3).
- evt_ready=0, 6 presses spread over buttons → fifo_count saturates at 4, remaining pending held; raise evt_ready → all 6 delivered in order, overflow=0.
- evt_ready=0, FIFO full, two press pulses on button 1 → overflow=1; ovf_clear pulse → overflow=0.
- With BTN_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold button 0 for 40 cycles → press, repeats at ~20, 25, 30, 35 cycles after press, then release; without macro → only press and release.
- Reset asserted with 3 events buffered → next cycle evt_valid=0, fifo_count=0, no stale events afterwards.
